// File: rtl/fwd_scoreboard.sv
// Operand forwarding across NSTAGE sources plus a long-latency busy scoreboard.
// Optional FWD_STALL_CNT_EN adds saturating stall/hazard cycle counters.
module fwd_scoreboard #(
  parameter int XLEN   = 64,
  parameter int RIDX   = 5,
  parameter int NRD    = 2,
  parameter int NSTAGE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic [NRD-1:0]         rs_valid_i,
  input  logic [NRD*RIDX-1:0]    rs_idx_i,
  input  logic [NRD*XLEN-1:0]    rf_data_i,
  input  logic [NSTAGE-1:0]      src_valid_i,
  input  logic [NSTAGE*RIDX-1:0] src_rd_idx_i,
  input  logic [NSTAGE-1:0]      src_data_ok_i,
  input  logic [NSTAGE*XLEN-1:0] src_data_i,
  input  logic                   issue_valid_i,
  input  logic                   issue_long_i,
  input  logic [RIDX-1:0]        issue_rd_idx_i,
  input  logic                   long_wb_valid_i,
  input  logic [RIDX-1:0]        long_wb_idx_i,
  output logic [NRD*XLEN-1:0]    rs_data_o,
  output logic [NRD-1:0]         rs_fwd_o,
  output logic                   stall_o,
  output logic [2**RIDX-1:0]     busy_o
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt_o,
  output logic [31:0]            hazard_cnt_o
`endif
);

  localparam int NREG = 2**RIDX;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NRD-1:0]  fwd_haz;
  logic [NRD-1:0]  sb_haz;
  logic            waw;
  logic            fire;

  always_comb begin
    logic            hit;
    logic [RIDX-1:0] idx;
    rs_data_o = rf_data_i;
    rs_fwd_o  = '0;
    fwd_haz   = '0;
    sb_haz    = '0;
    hit       = 1'b0;
    idx       = '0;
    for (int i = 0; i < NRD; i++) begin
      hit = 1'b0;
      idx = rs_idx_i[i*RIDX +: RIDX];
      // youngest match wins, even if its data is not ready yet
      for (int s = 0; s < NSTAGE; s++) begin
        if (!hit && rs_valid_i[i] && src_valid_i[s] &&
            src_rd_idx_i[s*RIDX +: RIDX] == idx &&
            idx != '0) begin
          hit = 1'b1;
          if (src_data_ok_i[s]) begin
            rs_data_o[i*XLEN +: XLEN] = src_data_i[s*XLEN +: XLEN];
            rs_fwd_o[i] = 1'b1;
          end else begin
            fwd_haz[i] = 1'b1;
          end
        end
      end
      if (rs_valid_i[i] && busy_q[idx] &&
          !(long_wb_valid_i && long_wb_idx_i == idx))
        sb_haz[i] = 1'b1;
    end
  end

  assign waw     = issue_valid_i & issue_long_i & busy_q[issue_rd_idx_i];
  assign stall_o = (|fwd_haz) | (|sb_haz) | waw;
  assign fire    = issue_valid_i & ~stall_o & ~flush_i;
  assign busy_o  = busy_q;

  always_comb begin
    busy_d = busy_q;
    if (long_wb_valid_i)
      busy_d[long_wb_idx_i] = 1'b0;
    if (fire && issue_long_i && issue_rd_idx_i != '0)
      busy_d[issue_rd_idx_i] = 1'b1;
    if (flush_i)
      busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] hazard_cnt_q, hazard_cnt_d;
  logic        sb_only;

  assign sb_only = (|sb_haz) & ~(|fwd_haz) & ~waw;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    hazard_cnt_d = hazard_cnt_q;
    if (stall_o && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (sb_only && hazard_cnt_q != '1)
      hazard_cnt_d = hazard_cnt_q + 32'd1;
    if (flush_i) begin
      stall_cnt_d  = '0;
      hazard_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      hazard_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      hazard_cnt_q <= hazard_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign hazard_cnt_o = hazard_cnt_q;
`endif

endmodule
